// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl
// Moves the car between three floors toward the goal floor from the selector.
// It times floor-to-floor travel and door dwell. On arrival it pulses arrive
// and the clear for the served floor.
//
// Build option: define DOOR_HOLD_EN to add the door_hold input. While door_hold
// is high in DOOR, the door dwell timer keeps reloading, so the door stays open.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | parked, doors closed, waiting for a valid goal and a request
// MOVE  | travelling toward target, one floor per TRAVEL_CYCLES clocks
// DOOR  | doors open at the served floor for DOOR_CYCLES clocks
module elevator_motion_ctrl #(
    parameter logic [1:0] labelF1       = 2'b00,
    parameter logic [1:0] labelF2       = 2'b01,
    parameter logic [1:0] labelF3       = 2'b10,
    parameter int         TRAVEL_CYCLES = 50,
    parameter int         DOOR_CYCLES   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gf,
    input  logic       led1,
    input  logic       led2,
    input  logic       led3,
`ifdef DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic [1:0] floor,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic       arrive,
    output logic       clr1,
    output logic       clr2,
    output logic       clr3
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [1:0]    target, target_n;
    logic [1:0]    floor_n;
    logic [TW-1:0] timer, timer_n;
    logic          moving_n, dir_up_n, door_open_n, arrive_n;
    logic [2:0]    clr_n;
    logic [1:0]    step_floor;
    logic          any_req;
    logic          hold_req;

    assign any_req = led1 | led2 | led3;

`ifdef DOOR_HOLD_EN
    assign hold_req = door_hold;
`else
    assign hold_req = 1'b0;
`endif

    // Floor reached after one travel interval. Floor 3 cannot step up and
    // floor 1 cannot step down, so the car stays on valid floors.
    always_comb begin
        step_floor = floor;
        if (dir_up) begin
            if (floor == labelF1)      step_floor = labelF2;
            else if (floor == labelF2) step_floor = labelF3;
        end else begin
            if (floor == labelF3)      step_floor = labelF2;
            else if (floor == labelF2) step_floor = labelF1;
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_n  = state;
        floor_n  = floor;
        target_n = target;
        timer_n  = timer;
        dir_up_n = dir_up;
        arrive_n = 1'b0;
        clr_n    = 3'b000;
        case (state)
            S_IDLE: begin
                if (any_req && (gf != 2'b11)) begin
                    if (gf == floor) begin
                        state_n  = S_DOOR;
                        timer_n  = DOOR_LOAD;
                        arrive_n = 1'b1;
                        clr_n    = {floor == labelF3, floor == labelF2, floor == labelF1};
                    end else begin
                        state_n  = S_MOVE;
                        target_n = gf;
                        dir_up_n = (gf > floor);
                        timer_n  = TRAVEL_LOAD;
                    end
                end
            end
            S_MOVE: begin
                if (timer == '0) begin
                    floor_n = step_floor;
                    if (step_floor == target) begin
                        state_n  = S_DOOR;
                        timer_n  = DOOR_LOAD;
                        arrive_n = 1'b1;
                        clr_n    = {step_floor == labelF3, step_floor == labelF2,
                                    step_floor == labelF1};
                    end else begin
                        timer_n = TRAVEL_LOAD;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_DOOR: begin
                if (hold_req) begin
                    timer_n = DOOR_LOAD;
                end else if (timer == '0) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        moving_n    = (state_n == S_MOVE);
        door_open_n = (state_n == S_DOOR);
    end

    // State and registered outputs; reset abandons any trip in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            floor     <= labelF1;
            target    <= labelF1;
            timer     <= '0;
            moving    <= 1'b0;
            dir_up    <= 1'b1;
            door_open <= 1'b0;
            arrive    <= 1'b0;
            clr1      <= 1'b0;
            clr2      <= 1'b0;
            clr3      <= 1'b0;
        end else begin
            state     <= state_n;
            floor     <= floor_n;
            target    <= target_n;
            timer     <= timer_n;
            moving    <= moving_n;
            dir_up    <= dir_up_n;
            door_open <= door_open_n;
            arrive    <= arrive_n;
            clr1      <= clr_n[0];
            clr2      <= clr_n[1];
            clr3      <= clr_n[2];
        end
    end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb_elevator_motion_ctrl
// Applies a table of trips, followed by hand-written sequences for door
// reopen, door hold (only when DOOR_HOLD_EN is defined) and reset during
// travel. Each expected arrival (floor and clock edge) goes into a queue when
// the request is driven. Every arrive pulse from the DUT is checked against
// the entry at the head of that queue.
module tb_elevator_motion_ctrl;

    localparam int T = 4;
    localparam int D = 6;
    localparam int BUDGET = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gf = 2'b00;
    logic       led1 = 1'b0, led2 = 1'b0, led3 = 1'b0;
`ifdef DOOR_HOLD_EN
    logic       door_hold = 1'b0;
`endif
    logic [1:0] floor;
    logic       moving, dir_up, door_open, arrive, clr1, clr2, clr3;

    elevator_motion_ctrl #(
        .TRAVEL_CYCLES(T),
        .DOOR_CYCLES  (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gf       (gf),
        .led1     (led1),
        .led2     (led2),
        .led3     (led3),
`ifdef DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .floor    (floor),
        .moving   (moving),
        .dir_up   (dir_up),
        .door_open(door_open),
        .arrive   (arrive),
        .clr1     (clr1),
        .clr2     (clr2),
        .clr3     (clr3)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    typedef struct {
        logic [1:0] fl;
        int         at_edge;
    } arr_t;
    arr_t sb[$];
    int   last_arr = 0;

    // Compare every arrive pulse with the head of the queue; a clear must never pulse alone.
    always @(negedge clk) begin
        if (arrive) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_arrive: got arrive at floor %0d, required none (edge %0d)",
                         floor, edge_cnt);
            end else begin
                arr_t a;
                a = sb.pop_front();
                check("arrive_floor", floor, a.fl);
                check("arrive_edge", edge_cnt, a.at_edge);
                check("arrive_clr", {clr3, clr2, clr1},
                      {a.fl == 2'b10, a.fl == 2'b01, a.fl == 2'b00});
                check("arrive_door", door_open, 1);
            end
            last_arr = edge_cnt;
        end else if (clr1 | clr2 | clr3) begin
            tests++;
            fails++;
            $display("FAIL clr_without_arrive: got clr=%b, required 000 (edge %0d)",
                     {clr3, clr2, clr1}, edge_cnt);
        end
    end

    typedef struct {
        logic [1:0] gf;
        logic [2:0] leds;     // {led3, led2, led1}
        int         n;        // floors travelled, -1 = no service expected
        logic [1:0] exp_floor;
        logic       exp_dir;
        logic       distract; // raise gf=01/led2 during the trip
    } vec_t;

    vec_t vecs[12];

    task automatic wait_queue_empty(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < BUDGET) begin
            @(negedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_door_closed(input string name, input int exp_len);
        int k;
        k = 0;
        while (door_open && k < BUDGET) begin
            @(negedge clk); #1;
            k++;
        end
        check({name, "_closed"}, door_open, 0);
        check({name, "_len"}, edge_cnt - last_arr, exp_len);
    endtask

    initial begin
        int e;
        vecs[0]  = '{2'b00, 3'b001,  0, 2'b00, 1'b1, 1'b0};
        vecs[1]  = '{2'b10, 3'b100,  2, 2'b10, 1'b1, 1'b1};
        vecs[2]  = '{2'b00, 3'b001,  2, 2'b00, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 3'b010,  1, 2'b01, 1'b1, 1'b0};
        vecs[4]  = '{2'b10, 3'b100,  1, 2'b10, 1'b1, 1'b0};
        vecs[5]  = '{2'b01, 3'b010,  1, 2'b01, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 3'b001,  1, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 3'b001, -1, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{2'b01, 3'b000, -1, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 3'b010,  2, 2'b10, 1'b1, 1'b0};
        vecs[10] = '{2'b10, 3'b100,  0, 2'b10, 1'b1, 1'b0};
        vecs[11] = '{2'b00, 3'b111,  2, 2'b00, 1'b0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_floor", floor, 0);
        check("rst_moving", moving, 0);
        check("rst_dir_up", dir_up, 1);
        check("rst_door", door_open, 0);
        check("rst_arrive", arrive, 0);
        check("rst_clr", {clr3, clr2, clr1}, 0);
        rst_n = 1'b1;

        // table-driven trips
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            e = edge_cnt;
            gf = vecs[i].gf;
            {led3, led2, led1} = vecs[i].leds;
            if (vecs[i].n >= 0) sb.push_back('{vecs[i].exp_floor, e + 1 + vecs[i].n * T});
            @(posedge clk); #1;
            if (vecs[i].n < 0) begin
                repeat (4) @(posedge clk);
                #1;
            end
            {led3, led2, led1} = 3'b000;
            if (vecs[i].distract) begin
                gf = 2'b01;
                led2 = 1'b1;
            end
            @(negedge clk); #1;
            check($sformatf("v%0d_moving", i), moving, (vecs[i].n > 0) ? 1 : 0);
            check($sformatf("v%0d_dir_up", i), dir_up, vecs[i].exp_dir);
            if (vecs[i].n == 0) check($sformatf("v%0d_door", i), door_open, 1);
            if (vecs[i].n < 0) check($sformatf("v%0d_door", i), door_open, 0);
            if (vecs[i].n == 2) begin
                repeat (T) @(negedge clk);
                #1;
                check($sformatf("v%0d_mid_floor", i), floor, 1);
                check($sformatf("v%0d_mid_moving", i), moving, 1);
            end
            if (vecs[i].n >= 0) begin
                wait_queue_empty($sformatf("v%0d_arrive", i));
                {led3, led2, led1} = 3'b000;
                wait_door_closed($sformatf("v%0d_door", i), D);
            end
            check($sformatf("v%0d_floor", i), floor, vecs[i].exp_floor);
        end

        // reopen: request at the current floor raised while the door is open
        @(posedge clk); #1;
        e = edge_cnt;
        gf = 2'b00;
        led1 = 1'b1;
        sb.push_back('{2'b00, e + 1});
        @(posedge clk); #1;
        led1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        led1 = 1'b1;
        sb.push_back('{2'b00, e + 1 + D + 1});
        wait_queue_empty("reopen");
        led1 = 1'b0;
        wait_door_closed("reopen_door", D);

`ifdef DOOR_HOLD_EN
        // door held for 10 clocks after opening
        @(posedge clk); #1;
        e = edge_cnt;
        gf = 2'b00;
        led1 = 1'b1;
        door_hold = 1'b1;
        sb.push_back('{2'b00, e + 1});
        @(posedge clk); #1;
        led1 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        door_hold = 1'b0;
        wait_queue_empty("hold");
        wait_door_closed("hold_door", 10 + D);
`endif

        // reset during travel abandons the trip
        @(posedge clk); #1;
        gf = 2'b10;
        led3 = 1'b1;
        @(posedge clk); #1;
        led3 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_moving", moving, 1);
        check("pre_rst_floor", floor, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_floor", floor, 0);
        check("mid_rst_moving", moving, 0);
        check("mid_rst_dir_up", dir_up, 1);
        check("mid_rst_door", door_open, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_floor", floor, 0);
        check("post_rst_moving", moving, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
